// File: rtl/gray_convert_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : gray_convert_pipe
//  Description : Pipelined binary/Gray converter with Gray increment/decrement
//                and valid/ready handshake on both sides (global-stall pipe).
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_convert_pipe #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wrap,
    output logic [15:0]      out_count
);

    localparam logic [1:0] C_MODE_B2G = 2'b00;
    localparam logic [1:0] C_MODE_G2B = 2'b01;
    localparam logic [1:0] C_MODE_INC = 2'b10;
    localparam logic [1:0] C_MODE_DEC = 2'b11;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    logic             advance;
    logic [PIPE-1:0]  vld_q;
    logic [WIDTH-1:0] op_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] res_d;
    logic             wrap_d;
    logic [15:0]      count_q;
    logic [15:0]      count_d;

    // Global stall: every stage moves together whenever the output slot frees up.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[PIPE-1];
    assign out_count = count_q;
    assign count_d   = count_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            op_q   <= '0;
            mode_q <= C_MODE_B2G;
        end else if (advance) begin
            vld_q[0] <= in_valid && in_ready;
            for (int i = 1; i < PIPE; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            op_q   <= in_data;
            mode_q <= in_mode;
        end
    end

    always_comb begin
        bin_d  = to_bin(op_q);
        res_d  = '0;
        wrap_d = 1'b0;
        case (mode_q)
            C_MODE_B2G: res_d = to_gray(op_q);
            C_MODE_G2B: res_d = bin_d;
            C_MODE_INC: begin
                res_d  = to_gray(bin_d + WIDTH'(1));
                wrap_d = &bin_d;
            end
            C_MODE_DEC: begin
                res_d  = to_gray(bin_d - WIDTH'(1));
                wrap_d = ~|bin_d;
            end
            default: res_d = '0;
        endcase
    end

    // With a single stage the result is formed straight from the operand register.
    generate
        if (PIPE == 1) begin : g_single
            assign out_data = res_d;
            assign out_wrap = wrap_d;
        end else begin : g_multi
            logic [WIDTH-1:0] res_q  [PIPE-1];
            logic             wrap_q [PIPE-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE - 1; i++) begin
                        res_q[i]  <= '0;
                        wrap_q[i] <= 1'b0;
                    end
                end else if (advance) begin
                    res_q[0]  <= res_d;
                    wrap_q[0] <= wrap_d;
                    for (int i = 1; i < PIPE - 1; i++) begin
                        res_q[i]  <= res_q[i-1];
                        wrap_q[i] <= wrap_q[i-1];
                    end
                end
            end

            assign out_data = res_q[PIPE-2];
            assign out_wrap = wrap_q[PIPE-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (out_valid && out_ready) begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire
